// File: rtl/sevenseg_scan_ctrl.sv
// rtl/sevenseg_scan_ctrl.sv - multiplexed 7-segment scan controller with blank window, PWM and blink
// Outputs are registered from next-state values so pins line up with the FSM state they describe.
module sevenseg_scan_ctrl #(
    parameter int N_DIGITS       = 4,
    parameter int SLOT_CYCLES    = 1000,
    parameter int BLANK_CYCLES   = 4,
    parameter int BRIGHT_W       = 4,
    parameter int BLINK_FRAMES   = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [N_DIGITS-1:0][7:0]      digit_seg,
    input  logic [BRIGHT_W-1:0]           brightness,
    input  logic [N_DIGITS-1:0]           blink_mask,
    output logic [7:0]                    seg_out,
    output logic [N_DIGITS-1:0]           an,
    output logic [$clog2(N_DIGITS)-1:0]   digit_idx,
    output logic                          frame_start
);

    localparam int IW = $clog2(N_DIGITS);
    localparam int SW = $clog2(SLOT_CYCLES);
    localparam int PW = SW + BRIGHT_W + 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [7:0]          SEG_OFF    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [N_DIGITS-1:0] AN_OFF     = AN_ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
    localparam logic [SW-1:0]       SLOT_LAST  = SW'(SLOT_CYCLES - 1);
    localparam logic [SW-1:0]       BLANK_LAST = SW'(BLANK_CYCLES - 1);
    localparam logic [SW:0]         BLANK_EXT  = (SW + 1)'(BLANK_CYCLES);
    localparam logic [IW-1:0]       DIGIT_LAST = IW'(N_DIGITS - 1);
    localparam logic [FW-1:0]       FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [PW-1:0]       ACTIVE_LEN = PW'(SLOT_CYCLES - BLANK_CYCLES);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BLANK = 2'd1;
    localparam logic [1:0] ON    = 2'd2;
    localparam logic [1:0] OFF   = 2'd3;

    logic [1:0]          state, state_n;
    logic [SW-1:0]       slot_cnt, slot_n;
    logic [IW-1:0]       idx_n;
    logic [FW-1:0]       frame_cnt, fcnt_n;
    logic                blink_phase, phase_n;
    logic [SW-1:0]       on_len, onlen_n;
    logic [7:0]          seg_lat, seglat_n;
    logic                fs_n;
    logic [7:0]          seg_n;
    logic [N_DIGITS-1:0] an_n;

    logic [PW-1:0]       on_prod;
    logic [SW-1:0]       on_len_new;
    logic [SW:0]         on_end;
    logic [SW:0]         slot_inc;
    logic                slot_end;
    logic [N_DIGITS-1:0] an_hot;
    logic [7:0]          seg_lit;

    // Full-precision product so the maximum code yields the whole on-window.
    assign on_prod    = ACTIVE_LEN * (PW'(brightness) + PW'(1));
    assign on_len_new = SW'(on_prod >> BRIGHT_W);
    assign on_end     = BLANK_EXT + {1'b0, on_len};
    assign slot_inc   = {1'b0, slot_cnt} + {{SW{1'b0}}, 1'b1};
    assign slot_end   = (slot_cnt == SLOT_LAST);

    always_comb begin
        state_n  = state;
        slot_n   = slot_cnt;
        idx_n    = digit_idx;
        fcnt_n   = frame_cnt;
        phase_n  = blink_phase;
        onlen_n  = on_len;
        seglat_n = seg_lat;
        fs_n     = 1'b0;

        if (!enable) begin
            state_n = IDLE;
            slot_n  = '0;
            idx_n   = '0;
            fcnt_n  = '0;
            phase_n = 1'b0;
        end else if (state == IDLE) begin
            state_n = BLANK;
            slot_n  = '0;
            idx_n   = '0;
            fs_n    = 1'b1;
            onlen_n = on_len_new;
        end else if (slot_end) begin
            state_n = BLANK;
            slot_n  = '0;
            onlen_n = on_len_new;
            if (digit_idx == DIGIT_LAST) begin
                idx_n = '0;
                fs_n  = 1'b1;
                if (frame_cnt == FRAME_LAST) begin
                    fcnt_n  = '0;
                    phase_n = ~blink_phase;
                end else begin
                    fcnt_n = frame_cnt + FW'(1);
                end
            end else begin
                idx_n = digit_idx + IW'(1);
            end
        end else begin
            slot_n = slot_cnt + SW'(1);
            case (state)
                BLANK: begin
                    if (slot_cnt == BLANK_LAST) begin
                        if (on_len == '0) begin
                            state_n = OFF;
                        end else begin
                            state_n  = ON;
                            seglat_n = digit_seg[digit_idx];
                        end
                    end
                end
                ON: begin
                    if (slot_inc == on_end) begin
                        state_n = OFF;
                    end
                end
                default: ;
            endcase
        end

        an_hot  = N_DIGITS'(1) << idx_n;
        seg_lit = (phase_n && blink_mask[idx_n]) ? 8'h00 : seglat_n;
        if (state_n == ON) begin
            an_n  = AN_ACTIVE_LOW ? ~an_hot : an_hot;
            seg_n = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
        end else begin
            an_n  = AN_OFF;
            seg_n = SEG_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            slot_cnt    <= '0;
            digit_idx   <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            on_len      <= '0;
            seg_lat     <= '0;
            seg_out     <= SEG_OFF;
            an          <= AN_OFF;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            slot_cnt    <= slot_n;
            digit_idx   <= idx_n;
            frame_cnt   <= fcnt_n;
            blink_phase <= phase_n;
            on_len      <= onlen_n;
            seg_lat     <= seglat_n;
            seg_out     <= seg_n;
            an          <= an_n;
            frame_start <= fs_n;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb/tb_sevenseg_scan_ctrl.sv - self-checking bench for sevenseg_scan_ctrl
module tb_sevenseg_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, enable;
    logic [3:0][7:0] digit_seg;
    logic [1:0]      brightness;
    logic [3:0]      blink_mask;
    logic [7:0]      seg_out;
    logic [3:0]      an;
    logic [1:0]      digit_idx;
    logic            frame_start;

    sevenseg_scan_ctrl #(
        .N_DIGITS(4), .SLOT_CYCLES(16), .BLANK_CYCLES(2), .BRIGHT_W(2),
        .BLINK_FRAMES(2), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .digit_seg(digit_seg),
        .brightness(brightness), .blink_mask(blink_mask), .seg_out(seg_out),
        .an(an), .digit_idx(digit_idx), .frame_start(frame_start)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs as seen by the DUT at each rising edge.
    logic            s_reset, s_en;
    logic [3:0][7:0] s_seg;
    logic [1:0]      s_b;
    logic [3:0]      s_mask;
    always @(posedge clk) begin
        s_reset <= reset;
        s_en    <= enable;
        s_seg   <= digit_seg;
        s_b     <= brightness;
        s_mask  <= blink_mask;
    end

    // Model: t counts cycles since scanning began; slot, digit and frame follow by division.
    int         t = -1;
    int         mlen = 0;
    logic [7:0] mseg = 8'h00;
    int         pos, dig;
    bit         ph;
    logic [3:0] e_an;
    logic [7:0] e_seg;
    logic [1:0] e_idx;
    logic       e_fs;
    bit         armed = 1'b0;

    always @(negedge clk) begin
        if (s_reset !== 1'b1 || s_en !== 1'b1) begin
            t = -1;
        end else begin
            t = t + 1;
            if (t % 16 == 0) mlen = (14 * (int'(s_b) + 1)) / 4;
            if (t % 16 == 2) mseg = s_seg[(t / 16) % 4];
        end
        e_an = 4'hF; e_seg = 8'hFF; e_idx = 2'd0; e_fs = 1'b0;
        if (t >= 0) begin
            pos   = t % 16;
            dig   = (t / 16) % 4;
            ph    = ((t / 64) / 2) % 2 == 1;
            e_idx = 2'(dig);
            e_fs  = (t % 64 == 0);
            if (pos >= 2 && pos < 2 + mlen) begin
                e_an  = ~(4'b0001 << dig);
                e_seg = (ph && s_mask[dig]) ? 8'hFF : ~mseg;
            end
        end
        if (armed) begin
            checks++;
            if ({an, seg_out, digit_idx, frame_start} !== {e_an, e_seg, e_idx, e_fs}) begin
                errors++;
                $display("FAIL model t=%0d: got an=%h seg=%h idx=%0d fs=%b expected an=%h seg=%h idx=%0d fs=%b",
                         t, an, seg_out, digit_idx, frame_start, e_an, e_seg, e_idx, e_fs);
            end
        end
    end

    int tt;
    int lit;
    logic [7:0] blink_exp [6];

    task automatic step();
        @(negedge clk);
        tt++;
    endtask

    task automatic count_slot(input int set_at, input logic [1:0] set_val);
        lit = 0;
        repeat (16) begin
            step();
            if (an !== 4'hF) lit++;
            if (tt == set_at) brightness = set_val;
        end
    endtask

    initial begin
        blink_exp = '{8'hC0, 8'hC0, 8'hFF, 8'hFF, 8'hC0, 8'hC0};
        reset = 1'b0; enable = 1'b0; brightness = 2'd3; blink_mask = 4'b0000;
        digit_seg = {8'h66, 8'h4F, 8'h5B, 8'h06};
        repeat (3) @(negedge clk);
        armed = 1'b1;
        chk("reset_an", an, 4'hF);
        chk("reset_seg", seg_out, 8'hFF);
        chk("reset_idx", digit_idx, 0);
        chk("reset_fs", frame_start, 0);

        reset = 1'b1; enable = 1'b1; tt = -1;
        repeat (128) begin
            step();
            case (tt)
                0:  begin chk("t0_fs", frame_start, 1); chk("t0_an", an, 4'hF); end
                1:  chk("t1_an", an, 4'hF);
                2:  begin chk("t2_an", an, 4'hE); chk("t2_seg", seg_out, 8'hF9); end
                15: chk("t15_an", an, 4'hE);
                16: chk("t16_an", an, 4'hF);
                18: chk("t18_an", an, 4'hD);
                50: chk("t50_an", an, 4'h7);
                63: chk("t63_fs", frame_start, 0);
                64: chk("t64_fs", frame_start, 1);
                default: ;
            endcase
        end

        brightness = 2'd1;
        count_slot(-1, 2'd0);
        chk("lit_b1", lit, 7);
        brightness = 2'd0;
        count_slot(150, 2'd3);
        chk("lit_b0_midwrite", lit, 3);
        count_slot(-1, 2'd0);
        chk("lit_b3_next", lit, 14);

        repeat (7) step();
        chk("on5_an", an, 4'h7);
        enable = 1'b0;
        step();
        chk("dis_an", an, 4'hF);
        chk("dis_seg", seg_out, 8'hFF);
        chk("dis_idx", digit_idx, 0);
        repeat (2) step();
        digit_seg[2] = 8'h3F; blink_mask = 4'b0100;
        enable = 1'b1; tt = -1;
        step();
        chk("reen_fs", frame_start, 1);
        chk("reen_idx", digit_idx, 0);
        chk("reen_an0", an, 4'hF);
        step();
        chk("reen_an1", an, 4'hF);
        step();
        chk("reen_an2", an, 4'hE);

        while (tt < 383) begin
            step();
            if (tt % 64 == 37) begin
                chk("blink_seg", seg_out, blink_exp[tt / 64]);
                chk("blink_an", an, 4'hB);
            end
        end

        while (tt < 440) step();
        chk("pre_rst_idx", digit_idx, 3);
        chk("pre_rst_an", an, 4'h7);
        reset = 1'b0;
        step();
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg_out, 8'hFF);
        chk("rst_idx", digit_idx, 0);
        chk("rst_fs", frame_start, 0);
        repeat (4) begin
            step();
            chk("rst_hold_an", an, 4'hF);
        end
        reset = 1'b1; tt = -1;
        step();
        chk("post_rst_fs", frame_start, 1);
        while (tt < 37) step();
        chk("post_rst_phase", seg_out, 8'hC0);

        repeat (10000) begin
            step();
            digit_seg  = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
            brightness = 2'($urandom);
            enable     = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 299) == 0) blink_mask = 4'($urandom);
            if (($countones(~an)) > 1) begin
                errors++;
                $display("FAIL an_onehot: got an=%h required at most one active", an);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
